// File: rtl/standoff_pkg.sv
// Shared encodings for the standoff game: player actions, sequencer states and winner codes.
// Also holds the per-round rules used by the sequencer (downgrade, ammo update, outcome).
package standoff_pkg;

    localparam int unsigned ACT_W  = 3;
    localparam int unsigned AMMO_W = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WIN_W  = 2;
    localparam int unsigned ST_W   = 3;

    localparam logic [ACT_W-1:0] ACT_SHOOT  = 3'b100;
    localparam logic [ACT_W-1:0] ACT_RELOAD = 3'b010;
    localparam logic [ACT_W-1:0] ACT_DUCK   = 3'b001;
    localparam logic [ACT_W-1:0] ACT_NONE   = 3'b000;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_RESOLVE   = 3'd2,
        ST_REVEAL    = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    localparam logic [WIN_W-1:0] WIN_NONE = 2'b00;
    localparam logic [WIN_W-1:0] WIN_P1   = 2'b01;
    localparam logic [WIN_W-1:0] WIN_P2   = 2'b10;
    localparam logic [WIN_W-1:0] WIN_BOTH = 2'b11;

    // Only the three real action codes count as a press; 000 and multi-hot codes do not.
    function automatic logic is_action(input logic [ACT_W-1:0] code);
        return (code == ACT_SHOOT) || (code == ACT_RELOAD) || (code == ACT_DUCK);
    endfunction

    // A shot with an empty gun is treated as doing nothing.
    function automatic logic [ACT_W-1:0] effective_action(input logic [ACT_W-1:0]  act,
                                                          input logic [AMMO_W-1:0] ammo);
        logic [ACT_W-1:0] eff;
        eff = act;
        if (act == ACT_SHOOT && ammo == '0) begin
            eff = ACT_NONE;
        end
        return eff;
    endfunction

    function automatic logic [AMMO_W-1:0] next_ammo(input logic [ACT_W-1:0]  eff,
                                                    input logic [AMMO_W-1:0] ammo,
                                                    input logic [AMMO_W-1:0] max_ammo);
        logic [AMMO_W-1:0] res;
        res = ammo;
        if (eff == ACT_SHOOT) begin
            res = ammo - AMMO_W'(1);
        end else if (eff == ACT_RELOAD && ammo < max_ammo) begin
            res = ammo + AMMO_W'(1);
        end
        return res;
    endfunction

    function automatic logic [WIN_W-1:0] round_winner(input logic [ACT_W-1:0] eff_p1,
                                                      input logic [ACT_W-1:0] eff_p2);
        logic [WIN_W-1:0] win;
        win = WIN_NONE;
        if (eff_p1 == ACT_SHOOT && eff_p2 == ACT_SHOOT) begin
            win = WIN_BOTH;
        end else if (eff_p1 == ACT_SHOOT) begin
            win = (eff_p2 == ACT_DUCK) ? WIN_NONE : WIN_P1;
        end else if (eff_p2 == ACT_SHOOT) begin
            win = (eff_p1 == ACT_DUCK) ? WIN_NONE : WIN_P2;
        end
        return win;
    endfunction

endpackage

// File: rtl/standoff_press_latch.sv
// Per-player press detector: registers the previous choice sample and latches the first
// fresh one-hot action while enabled; held until cleared for the next round.
module standoff_press_latch
    import standoff_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [ACT_W-1:0] choice_i,
    output logic             locked_o,
    output logic [ACT_W-1:0] act_o
);

    logic [ACT_W-1:0] prev_q;
    logic [ACT_W-1:0] act_q;
    logic             locked_q;
    logic             new_press_c;

    // A held key is not a new press; the code must change to count again.
    assign new_press_c = is_action(choice_i) && (choice_i != prev_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= ACT_NONE;
            act_q    <= ACT_NONE;
            locked_q <= 1'b0;
        end else begin
            prev_q <= choice_i;
            if (clr_i) begin
                act_q    <= ACT_NONE;
                locked_q <= 1'b0;
            end else if (en_i && !locked_q && new_press_c) begin
                act_q    <= choice_i;
                locked_q <= 1'b1;
            end
        end
    end

    assign locked_o = locked_q;
    assign act_o    = act_q;

endmodule

// File: rtl/standoff_round_ctrl.sv
// Round sequencer for the two-player standoff game: collects both choices within a window,
// resolves the round, tracks ammo, holds a reveal phase and declares the game winner.
module standoff_round_ctrl
    import standoff_pkg::*;
#(
    parameter int unsigned ROUND_CYCLES  = 100_000_000,
    parameter int unsigned REVEAL_CYCLES = 50_000_000,
    parameter int unsigned MAX_AMMO      = 3,
    parameter int unsigned START_AMMO    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ACT_W-1:0]  choicep1,
    input  logic [ACT_W-1:0]  choicep2,
    output logic [ST_W-1:0]   state_o,
    output logic              locked_p1,
    output logic              locked_p2,
    output logic [ACT_W-1:0]  last_p1,
    output logic [ACT_W-1:0]  last_p2,
    output logic [AMMO_W-1:0] ammo_p1,
    output logic [AMMO_W-1:0] ammo_p2,
    output logic [CNT_W-1:0]  round_cnt,
    output logic              result_valid,
    output logic [WIN_W-1:0]  winner,
    output logic              game_over
);

    localparam int unsigned TIMER_MAX = (ROUND_CYCLES > REVEAL_CYCLES) ? ROUND_CYCLES
                                                                       : REVEAL_CYCLES;
    localparam int unsigned TIMER_W   = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0] ROUND_LAST  = TIMER_W'(ROUND_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REVEAL_LAST = TIMER_W'(REVEAL_CYCLES - 1);
    localparam logic [AMMO_W-1:0]  AMMO_MAX    = AMMO_W'(MAX_AMMO);
    localparam logic [AMMO_W-1:0]  AMMO_START  = AMMO_W'(START_AMMO);

    state_e             state_q;
    logic [TIMER_W-1:0] timer_q;
    logic [ACT_W-1:0]   last_p1_q;
    logic [ACT_W-1:0]   last_p2_q;
    logic [AMMO_W-1:0]  ammo_p1_q;
    logic [AMMO_W-1:0]  ammo_p2_q;
    logic [CNT_W-1:0]   round_cnt_q;
    logic               result_valid_q;
    logic [WIN_W-1:0]   winner_q;
    logic               game_over_q;

    logic               lock_p1_c;
    logic               lock_p2_c;
    logic [ACT_W-1:0]   act_p1_c;
    logic [ACT_W-1:0]   act_p2_c;
    logic [ACT_W-1:0]   eff_p1_c;
    logic [ACT_W-1:0]   eff_p2_c;
    logic [AMMO_W-1:0]  ammo_p1_d;
    logic [AMMO_W-1:0]  ammo_p2_d;
    logic [WIN_W-1:0]   winner_d;
    logic               game_start_c;
    logic               reveal_done_c;
    logic               collect_en_c;
    logic               lock_clr_c;

    assign game_start_c  = ((state_q == ST_IDLE) || (state_q == ST_GAME_OVER)) && start;
    assign reveal_done_c = (state_q == ST_REVEAL) && (timer_q == REVEAL_LAST);
    assign collect_en_c  = (state_q == ST_COLLECT);
    assign lock_clr_c    = game_start_c || reveal_done_c;

    standoff_press_latch u_latch_p1 (
        .clk      (clk),
        .reset    (reset),
        .en_i     (collect_en_c),
        .clr_i    (lock_clr_c),
        .choice_i (choicep1),
        .locked_o (lock_p1_c),
        .act_o    (act_p1_c)
    );

    standoff_press_latch u_latch_p2 (
        .clk      (clk),
        .reset    (reset),
        .en_i     (collect_en_c),
        .clr_i    (lock_clr_c),
        .choice_i (choicep2),
        .locked_o (lock_p2_c),
        .act_o    (act_p2_c)
    );

    // Unlocked players carry ACT_NONE out of the latch, so only the empty-gun downgrade remains.
    assign eff_p1_c  = effective_action(act_p1_c, ammo_p1_q);
    assign eff_p2_c  = effective_action(act_p2_c, ammo_p2_q);
    assign ammo_p1_d = next_ammo(eff_p1_c, ammo_p1_q, AMMO_MAX);
    assign ammo_p2_d = next_ammo(eff_p2_c, ammo_p2_q, AMMO_MAX);
    assign winner_d  = round_winner(eff_p1_c, eff_p2_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            last_p1_q      <= ACT_NONE;
            last_p2_q      <= ACT_NONE;
            ammo_p1_q      <= '0;
            ammo_p2_q      <= '0;
            round_cnt_q    <= '0;
            result_valid_q <= 1'b0;
            winner_q       <= WIN_NONE;
            game_over_q    <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start) begin
                        state_q     <= ST_COLLECT;
                        timer_q     <= '0;
                        ammo_p1_q   <= AMMO_START;
                        ammo_p2_q   <= AMMO_START;
                        round_cnt_q <= '0;
                        winner_q    <= WIN_NONE;
                        game_over_q <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    // A lock landing on the expiry edge is already in the latch when RESOLVE reads it.
                    if ((lock_p1_c && lock_p2_c) || (timer_q == ROUND_LAST)) begin
                        state_q <= ST_RESOLVE;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                ST_RESOLVE: begin
                    last_p1_q      <= eff_p1_c;
                    last_p2_q      <= eff_p2_c;
                    ammo_p1_q      <= ammo_p1_d;
                    ammo_p2_q      <= ammo_p2_d;
                    winner_q       <= winner_d;
                    round_cnt_q    <= round_cnt_q + CNT_W'(1);
                    result_valid_q <= 1'b1;
                    timer_q        <= '0;
                    if (winner_d == WIN_NONE) begin
                        state_q <= ST_REVEAL;
                    end else begin
                        state_q     <= ST_GAME_OVER;
                        game_over_q <= 1'b1;
                    end
                end
                ST_REVEAL: begin
                    if (reveal_done_c) begin
                        state_q <= ST_COLLECT;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign state_o      = state_q;
    assign locked_p1    = lock_p1_c;
    assign locked_p2    = lock_p2_c;
    assign last_p1      = last_p1_q;
    assign last_p2      = last_p2_q;
    assign ammo_p1      = ammo_p1_q;
    assign ammo_p2      = ammo_p2_q;
    assign round_cnt    = round_cnt_q;
    assign result_valid = result_valid_q;
    assign winner       = winner_q;
    assign game_over    = game_over_q;

endmodule

// File: doc/standoff_round_ctrl.md
Name: standoff_round_ctrl

Overview:
- Round sequencer for the two-player standoff game.
- Consumes the one-hot per-player action codes from the keyboard decoder: shoot=100, reload=010, duck=001, none=000.
- Runs each round: collect/lock both choices within a time window, resolve outcome, track ammo, hold a reveal phase, declare the game winner.
- Feeds display/score logic downstream.

Parameters:
- ROUND_CYCLES, 100_000_000, collect-window length in clk cycles (1 s at 100 MHz).
- REVEAL_CYCLES, 50_000_000, reveal-phase length in clk cycles.
- MAX_AMMO, 3, ammo saturation value per player.
- START_AMMO, 1, ammo each player holds after start.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level/pulse; begins game from IDLE or GAME_OVER
- choicep1  in  3  P1 action code from decoder (level)
- choicep2  in  3  P2 action code from decoder (level)
- state_o  out  3  current FSM state encoding
- locked_p1  out  1  P1 choice latched this round
- locked_p2  out  1  P2 choice latched this round
- last_p1  out  3  effective P1 action of last resolved round
- last_p2  out  3  effective P2 action of last resolved round
- ammo_p1  out  2  P1 ammo count
- ammo_p2  out  2  P2 ammo count
- round_cnt  out  8  rounds resolved since start, wraps 255->0
- result_valid  out  1  one-cycle pulse on RESOLVE->REVEAL
- winner  out  2  00 none, 01 P1, 10 P2, 11 mutual kill
- game_over  out  1  high in GAME_OVER

Behaviour:
- Reset: state=IDLE; all outputs 0; timer 0; prev-sample regs 0.
- States: IDLE(0), COLLECT(1), RESOLVE(2), REVEAL(3), GAME_OVER(4).
- IDLE: on start -> COLLECT; ammo both = START_AMMO; round_cnt=0; winner=00; locks cleared; timer=0.
- Press detection (all states): register previous sample of each choice bus. New press = choice is exactly one-hot AND differs from previous sample. Non-one-hot or 000 never latches.
- COLLECT:
  - Per player, first new press latches the action and sets locked_px. Later presses are ignored until the next round.
  - Timer increments each cycle.
  - Go to RESOLVE when both are locked, or when timer == ROUND_CYCLES-1, whichever comes first.
  - An unlocked player has effective action none.
  - If a player locks in the same cycle the timer expires, the lock counts.
- RESOLVE (exactly 1 cycle):
  - Shoot with ammo 0 is downgraded to none.
  - last_px = effective actions.
  - Shooter ammo decrements by 1.
  - Reload increments ammo, saturating at MAX_AMMO.
  - Outcome:
    - Both shoot -> winner=11.
    - Exactly one shoots and the target is not ducking -> shooter wins (01/10).
    - Target ducks -> no winner.
  - round_cnt++.
  - Next state: REVEAL if winner==00, else GAME_OVER. result_valid pulses for 1 cycle in both cases.
- REVEAL: timer counts REVEAL_CYCLES, then -> COLLECT with locks cleared and timer=0. Presses during REVEAL are ignored.
- GAME_OVER: winner, last_px and ammo held; start -> same init as IDLE->COLLECT.
- start is ignored in COLLECT/RESOLVE/REVEAL.
- reset in any state, mid-round included, returns to IDLE next edge with outputs zeroed.
- Latency: choice edge -> locked_px high 1 cycle later. Second lock -> RESOLVE next cycle -> result_valid the cycle after.

Decomposition:
- Shared package standoff_pkg:
  - Action localparams: ACT_SHOOT=3'b100, ACT_RELOAD=3'b010, ACT_DUCK=3'b001, ACT_NONE=3'b000.
  - State encodings.
  - Winner codes.
  - These are shared with the decoder and display.
- One natural sub-module: standoff_press_latch, instantiated per player. It does the previous-sample register, one-hot check, and latch with clear.

Test Plan:
- reset mid-COLLECT with locked_p1=1 -> next cycle state_o=0, all outputs 0.
- start; P1 reload, P2 duck, both lock -> result_valid pulse; ammo_p1=2, ammo_p2=1; winner=00; round_cnt=1; REVEAL; then COLLECT after REVEAL_CYCLES (use small params, e.g. ROUND_CYCLES=20, REVEAL_CYCLES=5).
- P1 shoot (ammo 1), P2 reload -> winner=01, game_over=1, ammo_p1=0, ammo_p2=2, last_p1=100, last_p2=010.
- Both shoot with ammo 1 -> winner=11; P1 shoot with ammo 0 vs P2 duck -> last_p1=000, ammo unchanged, winner=00.
- Only P2 presses duck; timer expires at cycle 19 -> RESOLVE with last_p1=000; P1 held at 100 across a round boundary does not re-latch without changing; input 3'b110 is never latched.
- Reload 4 times -> ammo saturates at 3; start during REVEAL ignored; start in GAME_OVER reinitialises ammo to 1, round_cnt to 0.
